// File: rtl/ifu_fetch_queue.sv
// Instruction-fetch front end: AXI-lite read master toward the I-cache plus a small
// {pc, instr, err} FIFO drained by decode, with redirect/squash handling.
module ifu_fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'hbfc0_0000,
  parameter int          FIFO_AW  = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] m_axi_instr_araddr,
  output logic [2:0]  m_axi_instr_arprot,
  output logic        m_axi_instr_arvalid,
  input  logic        m_axi_instr_arready,
  input  logic [31:0] m_axi_instr_rdata,
  input  logic [1:0]  m_axi_instr_rresp,
  input  logic        m_axi_instr_rvalid,
  output logic        m_axi_instr_rready,
  output logic [31:0] m_axi_instr_awaddr,
  output logic [2:0]  m_axi_instr_awprot,
  output logic        m_axi_instr_awvalid,
  input  logic        m_axi_instr_awready,
  output logic [31:0] m_axi_instr_wdata,
  output logic [3:0]  m_axi_instr_wstrb,
  output logic        m_axi_instr_wvalid,
  input  logic        m_axi_instr_wready,
  input  logic [1:0]  m_axi_instr_bresp,
  input  logic        m_axi_instr_bvalid,
  output logic        m_axi_instr_bready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_err
);

  localparam int                 DEPTH   = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0]   DEPTH_C = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, DROP} state_t;

  state_t             state_q;
  logic [31:0]        pc_q;
  logic [31:0]        araddr_q;
  logic               arvalid_q;
  logic [FIFO_AW:0]   count_q;
  logic [FIFO_AW:0]   count_d;
  logic [FIFO_AW-1:0] wptr_q;
  logic [FIFO_AW-1:0] rptr_q;

  logic [31:0]        pc_mem  [DEPTH];
  logic [31:0]        ins_mem [DEPTH];
  logic               err_mem [DEPTH];

  logic        full;
  logic        pop;
  logic        rready;
  logic        r_hs;
  logic        push;
  logic [31:0] redir_pc;
  logic [31:0] pc_next;

  assign full     = (count_q == DEPTH_C);
  assign pop      = (count_q != '0) & inst_ready;
  assign rready   = (state_q == FETCH) ? (~full | pop) : 1'b1;
  assign r_hs     = m_axi_instr_rvalid & rready;
  assign push     = (state_q == FETCH) & r_hs & ~redirect_valid;
  assign redir_pc = {redirect_pc[31:2], 2'b00};
  assign pc_next  = pc_q + 32'd4;

  always_comb begin
    count_d = count_q;
    if (redirect_valid)
      count_d = '0;
    else
      count_d = count_q + {{FIFO_AW{1'b0}}, push} - {{FIFO_AW{1'b0}}, pop};
  end

  // Fetch FSM: araddr/arvalid are registered so they stay frozen for the whole miss.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      araddr_q  <= RESET_PC;
      arvalid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (redirect_valid) begin
            pc_q      <= redir_pc;
            araddr_q  <= redir_pc;
            arvalid_q <= 1'b1;
            state_q   <= FETCH;
          end else if (~full | pop) begin
            arvalid_q <= 1'b1;
            state_q   <= FETCH;
          end
        end
        FETCH: begin
          if (redirect_valid) begin
            pc_q <= redir_pc;
            if (r_hs) araddr_q <= redir_pc;
            else      state_q  <= DROP;
          end else if (r_hs) begin
            pc_q     <= pc_next;
            araddr_q <= pc_next;
            if (count_d == DEPTH_C) begin
              arvalid_q <= 1'b0;
              state_q   <= IDLE;
            end
          end
        end
        DROP: begin
          if (redirect_valid) pc_q <= redir_pc;
          // A redirect landing with the stale response must not leave us waiting for another one.
          if (r_hs) begin
            araddr_q  <= redirect_valid ? redir_pc : pc_q;
            arvalid_q <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
    end else begin
      count_q <= count_d;
      if (redirect_valid) begin
        wptr_q <= '0;
        rptr_q <= '0;
      end else begin
        if (push) wptr_q <= wptr_q + 1'b1;
        if (pop)  rptr_q <= rptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wptr_q]  <= pc_q;
      ins_mem[wptr_q] <= m_axi_instr_rdata;
      err_mem[wptr_q] <= (m_axi_instr_rresp != 2'b00);
    end
  end

  assign inst_valid = (count_q != '0);
  assign inst       = inst_valid ? ins_mem[rptr_q] : 32'd0;
  assign inst_pc    = inst_valid ? pc_mem[rptr_q]  : 32'd0;
  assign inst_err   = inst_valid ? err_mem[rptr_q] : 1'b0;

  assign m_axi_instr_araddr  = araddr_q;
  assign m_axi_instr_arprot  = 3'b100;
  assign m_axi_instr_arvalid = arvalid_q;
  assign m_axi_instr_rready  = rready;

  assign m_axi_instr_awaddr  = 32'd0;
  assign m_axi_instr_awprot  = 3'b000;
  assign m_axi_instr_awvalid = 1'b0;
  assign m_axi_instr_wdata   = 32'd0;
  assign m_axi_instr_wstrb   = 4'b0000;
  assign m_axi_instr_wvalid  = 1'b0;
  assign m_axi_instr_bready  = 1'b1;

  logic unused_ok;
  assign unused_ok = ^{m_axi_instr_arready, m_axi_instr_awready, m_axi_instr_wready,
                       m_axi_instr_bresp, m_axi_instr_bvalid, redirect_pc[1:0]};

endmodule

// File: tb/tb_ifu_fetch_queue.sv
// Bench for ifu_fetch_queue: behavioural I-cache responder plus a scoreboard of
// expected {pc, instr, err} entries checked as decode pops them.
module tb_ifu_fetch_queue;

  localparam logic [31:0] RESET_PC = 32'hbfc0_0000;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] MAGIC    = 32'h1357_9bdf;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_err;

  ifu_fetch_queue #(.RESET_PC(RESET_PC), .FIFO_AW(2)) dut (
    .clk(clk), .rst(rst),
    .m_axi_instr_araddr(araddr), .m_axi_instr_arprot(arprot),
    .m_axi_instr_arvalid(arvalid), .m_axi_instr_arready(arready),
    .m_axi_instr_rdata(rdata), .m_axi_instr_rresp(rresp),
    .m_axi_instr_rvalid(rvalid), .m_axi_instr_rready(rready),
    .m_axi_instr_awaddr(awaddr), .m_axi_instr_awprot(awprot),
    .m_axi_instr_awvalid(awvalid), .m_axi_instr_awready(awready),
    .m_axi_instr_wdata(wdata), .m_axi_instr_wstrb(wstrb),
    .m_axi_instr_wvalid(wvalid), .m_axi_instr_wready(wready),
    .m_axi_instr_bresp(bresp), .m_axi_instr_bvalid(bvalid),
    .m_axi_instr_bready(bready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_pc(inst_pc), .inst_err(inst_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    logic        err;
  } ent_t;

  ent_t        sb[$];
  int          n_chk = 0;
  int          n_pass = 0;
  // cache responder
  logic        busy = 1'b0;
  int          wcnt = 0;
  int          lat = 0;
  logic [31:0] req_addr = '0;
  logic [31:0] err_addr = 32'h0000_0001;
  // reference model
  logic [31:0] exp_pc = RESET_PC;
  logic        drop = 1'b0;
  // scenario knobs / observations
  logic        ir = 1'b1;
  logic        redir = 1'b0;
  logic [31:0] rpc = '0;
  logic        last_hs = 1'b0;
  logic        last_pop = 1'b0;
  int          hs_cnt = 0;
  int          err_seen = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic cycle();
    ent_t e;
    @(negedge clk);
    if (busy) begin
      check("ar_hold_valid", {31'd0, arvalid}, 32'd1);
      check("ar_hold_addr", araddr, req_addr);
    end else if (arvalid) begin
      busy     = 1'b1;
      req_addr = araddr;
      wcnt     = lat;
    end
    rvalid = 1'b0;
    if (busy) begin
      if (wcnt == 0) rvalid = 1'b1;
      else wcnt--;
    end
    rdata          = req_addr ^ MAGIC;
    rresp          = (req_addr == err_addr) ? 2'b10 : 2'b00;
    inst_ready     = ir;
    redirect_valid = redir;
    redirect_pc    = rpc;
    #1;
    check("inst_valid", {31'd0, inst_valid}, {31'd0, sb.size() != 0});
    last_hs  = rvalid && rready;
    last_pop = inst_valid && inst_ready;
    if (last_pop && sb.size() != 0) begin
      e = sb.pop_front();
      check("inst_pc", inst_pc, e.pc);
      check("inst", inst, e.data);
      check("inst_err", {31'd0, inst_err}, {31'd0, e.err});
      if (inst_err) err_seen++;
    end
    if (last_hs) begin
      hs_cnt++;
      if (redir || drop) begin
        drop = 1'b0;
      end else begin
        check("fetch_addr", req_addr, exp_pc);
        e.pc = exp_pc; e.data = req_addr ^ MAGIC; e.err = (req_addr == err_addr);
        sb.push_back(e);
        exp_pc = exp_pc + 32'd4;
        check("no_overflow", {31'd0, sb.size() <= DEPTH}, 32'd1);
      end
      busy = 1'b0;
    end
    if (redir) begin
      sb.delete();
      exp_pc = {rpc[31:2], 2'b00};
      if (busy) drop = 1'b1;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic pulse_redirect(input logic [31:0] pc);
    rpc = pc; redir = 1'b1;
    cycle();
    redir = 1'b0;
  endtask

  initial begin
    rst = 1'b0; arready = 1'b1; rdata = '0; rresp = '0; rvalid = 1'b0;
    awready = 1'b0; wready = 1'b0; bresp = '0; bvalid = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_arvalid", {31'd0, arvalid}, 32'd0);
    check("rst_araddr", araddr, RESET_PC);
    check("rst_rready", {31'd0, rready}, 32'd1);
    check("rst_arprot", {29'd0, arprot}, 32'd4);
    check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    check("rst_inst", inst, 32'd0);
    check("rst_inst_pc", inst_pc, 32'd0);
    check("rst_inst_err", {31'd0, inst_err}, 32'd0);
    check("tie_aw_w", {29'd0, awvalid, wvalid, bready}, 32'd1);
    @(negedge clk);
    rst = 1'b1;

    // streaming hits, decode always ready
    lat = 0; ir = 1'b1;
    run(3);
    hs_cnt = 0;
    run(8);
    check("t1_rate", hs_cnt, 32'd8);

    // decode stalled: FIFO fills, then one pop buys exactly one fetch
    ir = 1'b0;
    pulse_redirect(32'h0000_1000);
    hs_cnt = 0;
    run(10);
    check("t2_fill", hs_cnt, 32'd4);
    check("t2_arvalid_drop", {31'd0, arvalid}, 32'd0);
    hs_cnt = 0;
    ir = 1'b1; cycle(); ir = 1'b0;
    run(10);
    check("t2_one_more", hs_cnt, 32'd1);
    ir = 1'b1;
    run(8);

    // slow misses
    lat = 10;
    run(25);

    // redirect in the middle of a miss
    for (int i = 0; i < 30 && !(busy && wcnt == 5); i++) cycle();
    check("t4_in_miss", {31'd0, busy && wcnt == 5}, 32'd1);
    pulse_redirect(32'h8000_0100);
    check("t4_no_hs", {31'd0, last_hs}, 32'd0);
    lat = 0;
    run(15);

    // redirect coincident with R handshake and pop
    run(5);
    pulse_redirect(32'h8000_2000);
    check("t5_hs", {31'd0, last_hs}, 32'd1);
    check("t5_pop", {31'd0, last_pop}, 32'd1);
    run(6);

    // bus error on one fetch, misaligned redirect
    err_addr = 32'h8000_0104;
    err_seen = 0;
    pulse_redirect(32'h8000_0103);
    run(8);
    check("t6_err_seen", err_seen, 32'd1);

    // pc wraps past 2^32
    pulse_redirect(32'hffff_fff8);
    run(6);

    // reset in the middle of a miss
    lat = 10;
    run(3);
    @(negedge clk);
    rst = 1'b0; rvalid = 1'b0;
    #1;
    check("mid_rst_arvalid", {31'd0, arvalid}, 32'd0);
    check("mid_rst_araddr", araddr, RESET_PC);
    check("mid_rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    busy = 1'b0; drop = 1'b0; sb.delete(); exp_pc = RESET_PC;
    @(negedge clk);
    rst = 1'b1;
    lat = 0;
    run(8);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
